// File: rtl/prog_loader_pkg.sv
// prog_loader_pkg
// Shared MCU definitions for the boot-time program loader: FSM state
// encoding, the instruction byte width and the default instruction memory
// geometry.
// Ports: none (package).
package prog_loader_pkg;

    localparam int BYTE_W          = 8;
    localparam int DEF_IMEM_DEPTH  = 256;
    localparam int DEF_ADDR_W      = 8;

    localparam logic [2:0] ENC_IDLE  = 3'd0;
    localparam logic [2:0] ENC_LEN   = 3'd1;
    localparam logic [2:0] ENC_DATA  = 3'd2;
    localparam logic [2:0] ENC_CSUM  = 3'd3;
    localparam logic [2:0] ENC_DONE  = 3'd4;
    localparam logic [2:0] ENC_ERROR = 3'd5;

    typedef enum logic [2:0] {
        ST_IDLE  = ENC_IDLE,
        ST_LEN   = ENC_LEN,
        ST_DATA  = ENC_DATA,
        ST_CSUM  = ENC_CSUM,
        ST_DONE  = ENC_DONE,
        ST_ERROR = ENC_ERROR
    } state_t;

endpackage

// File: rtl/prog_loader.sv
// prog_loader
// Boot-time loader that fills the MCU instruction memory from a byte stream
// (length header, N instruction bytes, optional checksum) and keeps the MCU
// in reset until the image is in place.
//
// Optional feature macro: PROG_LOADER_CHECKSUM_EN
//   defined   -> a trailing 8-bit sum byte is required and checked
//   undefined -> no checksum state or accumulator; DATA ends the session
//
// Ports:
//   Clk      in   rising-edge clock
//   Reset    in   asynchronous active-low reset
//   Start    in   begin a session (honoured in IDLE, DONE, ERROR)
//   InValid  in   input byte valid
//   InData   in   input byte
//   InReady  out  loader accepts a byte (LEN, DATA, CSUM)
//   MemWe    out  instruction memory write enable (one cycle per byte)
//   MemAddr  out  instruction memory write address
//   MemData  out  instruction memory write data
//   McuHold  out  holds the MCU in reset when high
//   resetPC  out  one-cycle pulse zeroing the MCU program counter
//   Busy     out  session in progress
//   Done     out  last session loaded successfully
//   Error    out  last session failed
module prog_loader
    import prog_loader_pkg::*;
#(
    parameter int IMEM_DEPTH = DEF_IMEM_DEPTH,
    parameter int ADDR_W     = DEF_ADDR_W
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              Start,
    input  logic              InValid,
    input  logic [BYTE_W-1:0] InData,
    output logic              InReady,
    output logic              MemWe,
    output logic [ADDR_W-1:0] MemAddr,
    output logic [BYTE_W-1:0] MemData,
    output logic              McuHold,
    output logic              resetPC,
    output logic              Busy,
    output logic              Done,
    output logic              Error
);

    // One extra bit so a full-depth image never needs wrap handling.
    localparam int CNT_W = ADDR_W + 1;

    state_t            state;
    logic [CNT_W-1:0]  count;
    logic [CNT_W-1:0]  len;
    logic [CNT_W-1:0]  count_inc;
    logic              xfer;
    logic              len_ok;
    logic              last_byte;
`ifdef PROG_LOADER_CHECKSUM_EN
    logic [BYTE_W-1:0] sum;
`endif

    assign xfer      = InValid && InReady;
    assign count_inc = count + CNT_W'(1);
    assign last_byte = (count_inc == len);
    assign len_ok    = (InData != '0) && (int'(InData) <= IMEM_DEPTH);

`ifdef PROG_LOADER_CHECKSUM_EN
    // Running sum of the instruction bytes, cleared when a session starts.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            sum <= '0;
        end else if ((state == ST_IDLE) || (state == ST_DONE) || (state == ST_ERROR)) begin
            if (Start) begin
                sum <= '0;
            end
        end else if ((state == ST_DATA) && xfer) begin
            sum <= sum + InData;
        end
    end
`endif

    // Loader FSM; every output is registered alongside the state so the
    // status flags are clean decodes of the state just entered.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state   <= ST_IDLE;
            count   <= '0;
            len     <= '0;
            InReady <= 1'b0;
            MemWe   <= 1'b0;
            MemAddr <= '0;
            MemData <= '0;
            McuHold <= 1'b1;
            resetPC <= 1'b0;
            Busy    <= 1'b0;
            Done    <= 1'b0;
            Error   <= 1'b0;
        end else begin
            MemWe   <= 1'b0;
            resetPC <= 1'b0;
            case (state)
                ST_IDLE, ST_DONE, ST_ERROR: begin
                    if (Start) begin
                        state   <= ST_LEN;
                        count   <= '0;
                        InReady <= 1'b1;
                        Busy    <= 1'b1;
                        Done    <= 1'b0;
                        Error   <= 1'b0;
                        McuHold <= 1'b1;
                    end
                end
                ST_LEN: begin
                    if (xfer) begin
                        len <= CNT_W'(InData);
                        if (len_ok) begin
                            state <= ST_DATA;
                        end else begin
                            state   <= ST_ERROR;
                            InReady <= 1'b0;
                            Busy    <= 1'b0;
                            Error   <= 1'b1;
                        end
                    end
                end
                ST_DATA: begin
                    if (xfer) begin
                        MemWe   <= 1'b1;
                        MemAddr <= count[ADDR_W-1:0];
                        MemData <= InData;
                        count   <= count_inc;
                        if (last_byte) begin
`ifdef PROG_LOADER_CHECKSUM_EN
                            state <= ST_CSUM;
`else
                            state   <= ST_DONE;
                            InReady <= 1'b0;
                            Busy    <= 1'b0;
                            Done    <= 1'b1;
                            McuHold <= 1'b0;
                            resetPC <= 1'b1;
`endif
                        end
                    end
                end
`ifdef PROG_LOADER_CHECKSUM_EN
                ST_CSUM: begin
                    if (xfer) begin
                        InReady <= 1'b0;
                        Busy    <= 1'b0;
                        if (InData == sum) begin
                            state   <= ST_DONE;
                            Done    <= 1'b1;
                            McuHold <= 1'b0;
                            resetPC <= 1'b1;
                        end else begin
                            state <= ST_ERROR;
                            Error <= 1'b1;
                        end
                    end
                end
`endif
                default: begin
                    state   <= ST_IDLE;
                    InReady <= 1'b0;
                    Busy    <= 1'b0;
                    Done    <= 1'b0;
                    Error   <= 1'b0;
                    McuHold <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_prog_loader.sv
// tb_prog_loader
// Self-checking bench for prog_loader. Stimulus pushes every expected
// instruction-memory write into a scoreboard queue; a monitor pops and
// compares whenever MemWe is seen. A second instance with IMEM_DEPTH = 16
// covers the depth-dependent length check.
// Honours PROG_LOADER_CHECKSUM_EN the same way as the design.
module tb_prog_loader;

    typedef struct {
        int addr;
        int data;
    } write_t;

    logic       clk = 1'b0;
    logic       resetN;
    logic       start;
    logic       inValid;
    logic [7:0] inData;
    logic       inReady;
    logic       memWe;
    logic [7:0] memAddr;
    logic [7:0] memData;
    logic       mcuHold;
    logic       resetPc;
    logic       busy;
    logic       done;
    logic       error;

    logic       sStart;
    logic       sValid;
    logic [7:0] sData;
    logic       sReady;
    logic       sMemWe;
    logic [3:0] sMemAddr;
    logic [7:0] sMemData;
    logic       sMcuHold;
    logic       sResetPc;
    logic       sBusy;
    logic       sDone;
    logic       sError;

    int         errors = 0;
    int         checks = 0;
    int         weCount = 0;
    int         rpcCount = 0;
    write_t     expQ[$];
    logic [7:0] payload[$];

    always #5 clk = ~clk;

    prog_loader #(.IMEM_DEPTH(256), .ADDR_W(8)) dut (
        .Clk(clk), .Reset(resetN), .Start(start), .InValid(inValid),
        .InData(inData), .InReady(inReady), .MemWe(memWe), .MemAddr(memAddr),
        .MemData(memData), .McuHold(mcuHold), .resetPC(resetPc), .Busy(busy),
        .Done(done), .Error(error)
    );

    prog_loader #(.IMEM_DEPTH(16), .ADDR_W(4)) dutSmall (
        .Clk(clk), .Reset(resetN), .Start(sStart), .InValid(sValid),
        .InData(sData), .InReady(sReady), .MemWe(sMemWe), .MemAddr(sMemAddr),
        .MemData(sMemData), .McuHold(sMcuHold), .resetPC(sResetPc), .Busy(sBusy),
        .Done(sDone), .Error(sError)
    );

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Scoreboard monitor: every write must match the head of the queue.
    always @(negedge clk) begin
        write_t e;
        if (resetPc === 1'b1) rpcCount++;
        if (memWe === 1'b1) begin
            weCount++;
            if (expQ.size() == 0) begin
                checkOutput("unexpected write", 1, 0);
            end else begin
                e = expQ.pop_front();
                checkOutput("write addr", int'(memAddr), e.addr);
                checkOutput("write data", int'(memData), e.data);
            end
        end
    end

    // Offer one byte and hold it until the loader takes it; ends just after
    // the accepting rising edge so back-to-back calls stream one per cycle.
    task automatic applyStimulus(input logic [7:0] b, input bit isWrite, input int addr);
        int n;
        n = 0;
        @(negedge clk);
        inValid = 1'b1;
        inData  = b;
        if (isWrite) expQ.push_back('{addr, int'(b)});
        while (!inReady && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) checkOutput("ready timeout", 0, 1);
        @(posedge clk);
    endtask

    task automatic pulseStart();
        @(negedge clk);
        inValid = 1'b0;
        start   = 1'b1;
        @(negedge clk);
        start   = 1'b0;
    endtask

    // Full session from the payload queue; csumDelta corrupts the checksum.
    task automatic runLoad(input int csumDelta);
        logic [7:0] s;
        s = 8'h00;
        pulseStart();
        applyStimulus(8'(payload.size()), 1'b0, 0);
        for (int i = 0; i < payload.size(); i++) begin
            applyStimulus(payload[i], 1'b1, i);
            s = s + payload[i];
        end
`ifdef PROG_LOADER_CHECKSUM_EN
        applyStimulus(s + 8'(csumDelta), 1'b0, 0);
`else
        checkOutput("csum delta unused", csumDelta, csumDelta & 0);
`endif
        @(negedge clk);
        inValid = 1'b0;
    endtask

    // Called on the negedge right after the final accepted byte.
    task automatic checkRelease(input string tag);
        checkOutput({tag, " McuHold"}, mcuHold, 0);
        checkOutput({tag, " resetPC"}, resetPc, 1);
        checkOutput({tag, " Done"}, done, 1);
        checkOutput({tag, " Error"}, error, 0);
        checkOutput({tag, " Busy"}, busy, 0);
        checkOutput({tag, " InReady"}, inReady, 0);
        @(negedge clk);
        checkOutput({tag, " resetPC pulse end"}, resetPc, 0);
        checkOutput({tag, " Done held"}, done, 1);
        checkOutput({tag, " McuHold held"}, mcuHold, 0);
    endtask

    task automatic checkResetValues(input string tag);
        checkOutput({tag, " InReady"}, inReady, 0);
        checkOutput({tag, " MemWe"}, memWe, 0);
        checkOutput({tag, " MemAddr"}, int'(memAddr), 0);
        checkOutput({tag, " MemData"}, int'(memData), 0);
        checkOutput({tag, " McuHold"}, mcuHold, 1);
        checkOutput({tag, " resetPC"}, resetPc, 0);
        checkOutput({tag, " Busy"}, busy, 0);
        checkOutput({tag, " Done"}, done, 0);
        checkOutput({tag, " Error"}, error, 0);
    endtask

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation did not complete");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int rpcBefore;
        int weBefore;

        resetN = 1'b1;
        start = 1'b0; inValid = 1'b0; inData = 8'h00;
        sStart = 1'b0; sValid = 1'b0; sData = 8'h00;
        #3 resetN = 1'b0;
        repeat (2) @(negedge clk);
        checkResetValues("reset");
        resetN = 1'b1;
        @(negedge clk);
        checkResetValues("idle");

        // Start latency: ready the cycle after Start is sampled.
        pulseStart();
        checkOutput("start InReady", inReady, 1);
        checkOutput("start Busy", busy, 1);
        checkOutput("start McuHold", mcuHold, 1);

        // Nominal load: 03 A1 B2 C3 (+16 checksum). Already in LEN.
        applyStimulus(8'h03, 1'b0, 0);
        applyStimulus(8'hA1, 1'b1, 0);
        applyStimulus(8'hB2, 1'b1, 1);
        applyStimulus(8'hC3, 1'b1, 2);
`ifdef PROG_LOADER_CHECKSUM_EN
        applyStimulus(8'h16, 1'b0, 0);
`endif
        @(negedge clk);
        inValid = 1'b0;
        checkRelease("nominal");

`ifdef PROG_LOADER_CHECKSUM_EN
        // Bad checksum: 02 10 20 31 (sum is 30).
        #1 rpcBefore = rpcCount;
        payload = '{8'h10, 8'h20};
        runLoad(1);
        checkOutput("badcsum Error", error, 1);
        checkOutput("badcsum McuHold", mcuHold, 1);
        checkOutput("badcsum Done", done, 0);
        @(negedge clk);
        #1 checkOutput("badcsum no resetPC", rpcCount, rpcBefore);
        pulseStart();
        checkOutput("badcsum Start clears Error", error, 0);
        checkOutput("badcsum restart McuHold", mcuHold, 1);
`else
        payload = '{8'h10, 8'h20};
        runLoad(0);
        checkRelease("two-byte");
`endif

        // Illegal length 00: error, no writes, then Start clears it.
        #1 weBefore = weCount;
        pulseStart();
        applyStimulus(8'h00, 1'b0, 0);
        @(negedge clk);
        inValid = 1'b0;
        checkOutput("len0 Error", error, 1);
        checkOutput("len0 McuHold", mcuHold, 1);
        checkOutput("len0 Busy", busy, 0);
        checkOutput("len0 InReady", inReady, 0);
        repeat (2) @(negedge clk);
        #1 checkOutput("len0 no MemWe", weCount, weBefore);
        pulseStart();
        checkOutput("len0 Start clears Error", error, 0);
        checkOutput("len0 restart InReady", inReady, 1);

        // Depth-16 instance: 0x11 is too long, 0x10 is accepted.
        @(negedge clk);
        sStart = 1'b1;
        @(negedge clk);
        sStart = 1'b0;
        sValid = 1'b1;
        sData  = 8'h11;
        checkOutput("small start InReady", sReady, 1);
        @(negedge clk);
        sValid = 1'b0;
        checkOutput("small len 0x11 Error", sError, 1);
        checkOutput("small len 0x11 MemWe", sMemWe, 0);
        checkOutput("small len 0x11 McuHold", sMcuHold, 1);
        sStart = 1'b1;
        @(negedge clk);
        sStart = 1'b0;
        sValid = 1'b1;
        sData  = 8'h10;
        @(negedge clk);
        sValid = 1'b0;
        checkOutput("small len 0x10 Error", sError, 0);
        checkOutput("small len 0x10 Busy", sBusy, 1);
        checkOutput("small len 0x10 InReady", sReady, 1);
        checkOutput("small len 0x10 resetPC", sResetPc, 0);
        checkOutput("small len 0x10 Done", sDone, 0);
        checkOutput("small len 0x10 MemAddr", int'(sMemAddr), 0);
        checkOutput("small len 0x10 MemData", int'(sMemData), 0);

        // Backpressure: idle cycle and a Start pulse between data bytes.
        #1 weBefore = weCount;
        pulseStart();
        applyStimulus(8'h04, 1'b0, 0);
        payload = '{8'h11, 8'h22, 8'h33, 8'h44};
        for (int i = 0; i < 4; i++) begin
            applyStimulus(payload[i], 1'b1, i);
            if (i < 3) begin
                @(negedge clk);
                inValid = 1'b0;
                start   = 1'b1;
                @(negedge clk);
                start   = 1'b0;
                checkOutput("stall Busy", busy, 1);
                checkOutput("stall InReady", inReady, 1);
                checkOutput("stall McuHold", mcuHold, 1);
            end
        end
`ifdef PROG_LOADER_CHECKSUM_EN
        applyStimulus(8'hAA, 1'b0, 0);
`endif
        @(negedge clk);
        inValid = 1'b0;
        checkRelease("stall");
        #1 checkOutput("stall write count", weCount - weBefore, 4);

        // Reset asserted after the second data byte of a 5-byte load.
        pulseStart();
        applyStimulus(8'h05, 1'b0, 0);
        applyStimulus(8'h01, 1'b1, 0);
        applyStimulus(8'h02, 1'b1, 1);
        @(negedge clk);
        inValid = 1'b0;
        #2 resetN = 1'b0;
        #1 checkResetValues("mid reset");
        checkOutput("mid reset queue empty", expQ.size(), 0);
        @(negedge clk);
        resetN = 1'b1;
        payload = '{8'h5A, 8'hA5};
        runLoad(0);
        checkRelease("after reset");

        // Full depth: length 00 rejected, then 255 bytes of 01.
        pulseStart();
        applyStimulus(8'h00, 1'b0, 0);
        @(negedge clk);
        inValid = 1'b0;
        checkOutput("full len0 Error", error, 1);
        payload = {};
        for (int i = 0; i < 255; i++) payload.push_back(8'h01);
        runLoad(0);
        checkOutput("full last MemAddr", int'(memAddr), 254);
        checkRelease("full");

        repeat (2) @(negedge clk);
        checkOutput("scoreboard drained", expQ.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
